ready_delay: RTL and testbench
==============================

Name: ready_delay

Overview:
- Valid/ready pipeline stage that registers the backward (ready) path. It complements the team's forward-registered data stage.
- Two-entry skid buffer: ready_o is driven from a flop, so the combinational ready chain between the bloom-filter hash/lookup stages is broken.
- Full throughput (1 word/cycle), in-order, no loss or duplication.

Parameters:
- DATA_W, 32, payload width in bits
- CNT_W, 32, width of statistics counters (used only with READY_DELAY_STATS_EN)

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  asynchronous, active-low reset
- data_i  in  DATA_W  upstream payload
- valid_i  in  1  upstream valid
- ready_o  out  1  upstream ready; registered, no combinational path from ready_i
- data_o  out  DATA_W  downstream payload
- valid_o  out  1  downstream valid
- ready_i  in  1  downstream ready
- clr_stats_i  in  1  synchronous stats clear (READY_DELAY_STATS_EN only)
- xfer_cnt_o  out  CNT_W  accepted-output transfer count (READY_DELAY_STATS_EN only)
- stall_cnt_o  out  CNT_W  backpressure cycle count (READY_DELAY_STATS_EN only)

Behaviour:
- Reset: the clock and reset are already decided as one clock; reset is asynchronous and active-low.
  - arst_n_i low → state EMPTY, valid_o=0, ready_o=1, data_o=0, skid register=0, counters=0.
  - Inputs are ignored while reset is asserted.
- Handshake:
  - in_fire = valid_i && ready_o; out_fire = valid_o && ready_i.
  - valid_o, once high, stays high with data_o stable until out_fire.
  - valid_i may drop at any time without effect.
- Storage: output register OUT and skid register SKD, each DATA_W wide.
- State machine:
  - EMPTY: valid_o=0, ready_o=1. in_fire → OUT<=data_i, go to BUSY.
  - BUSY: valid_o=1, ready_o=1.
    - in_fire && out_fire → OUT<=data_i, stay in BUSY.
    - in_fire && !out_fire → SKD<=data_i, go to FULL; ready_o drops next cycle.
    - !in_fire && out_fire → EMPTY.
    - Neither → hold.
  - FULL: valid_o=1, ready_o=0. out_fire → OUT<=SKD, go to BUSY. Otherwise hold. in_fire is impossible in FULL.
- Outputs: ready_o = (state != FULL), decoded from registered state. valid_o = (state != EMPTY).
- Latency: 1 cycle from in_fire to valid_o when OUT is free. A word is never bypassed combinationally.
- Ordering: OUT always holds the older word, SKD the newer.
- Sustained ready_i=1: one word per cycle, state stays BUSY.
- Sustained ready_i=0: at most 2 words accepted, then ready_o=0.
- Illegal state encoding → EMPTY (default branch).

Optional Feature:
- Macro: READY_DELAY_STATS_EN.
- Defined:
  - xfer_cnt_o increments on every out_fire.
  - stall_cnt_o increments on every cycle with valid_o && !ready_i.
  - Both saturate at all-ones; no wrap.
  - clr_stats_i=1 zeroes both on the next edge and takes priority over increment in the same cycle.
- Not defined: clr_stats_i, xfer_cnt_o and stall_cnt_o are absent; the datapath is identical.

Decomposition:
- Package ready_delay_pkg:
  - typedef enum logic [1:0] rd_state_t {RD_EMPTY, RD_BUSY, RD_FULL}.
  - Constant RD_IDLE_READY = 1'b1.
- Sub-module sat_counter (params CNT_W; ports clk_i, arst_n_i, clr_i, inc_i, cnt_o) instantiated twice under the macro. The datapath FSM stays in ready_delay.

Test Plan:
- Reset mid-transfer:
  - Fill to FULL with 0xA1, 0xA2, then pulse arst_n_i low asynchronously (between edges).
  - Required: valid_o=0 and ready_o=1 immediately; after release, the next input 0xB0 appears 1 cycle later with no trace of 0xA1/0xA2.
- Streaming:
  - ready_i=1, valid_i=1 for 8 cycles with data 0..7.
  - Required: data_o 0..7 on consecutive cycles starting 1 cycle after the first input; ready_o never drops; state stays BUSY.
- Backpressure fill:
  - ready_i=0, send 0x11, 0x22, 0x33.
  - Required: only 0x11 and 0x22 accepted; ready_o=0 from the cycle after 0x22 is accepted; 0x33 is held by the source. Then ready_i=1: output 0x11, 0x22, 0x33 in order.
- Random stalls:
  - 1000 words, valid_i and ready_i each 50% random.
  - Required: scoreboard exact order match; ready_o never depends combinationally on ready_i (toggle ready_i mid-cycle, ready_o unchanged).
- Drain to empty:
  - BUSY with 0x5A, valid_i=0, ready_i=1.
  - Required: one out_fire, then valid_o=0, state EMPTY.
- Stats (macro defined, CNT_W=4):
  - 20 stall cycles → stall_cnt_o saturates at 15.
  - clr_stats_i asserted together with an out_fire → xfer_cnt_o=0 next cycle.

Source files
------------

// File: rtl/ready_delay_pkg.sv
// ready_delay_pkg: shared state encoding and constants for the ready_delay
// skid-buffer stage.
package ready_delay_pkg;

    // Occupancy-oriented states: EMPTY (no word), BUSY (OUT holds a word),
    // FULL (OUT and SKD both hold words, upstream is stalled).
    typedef enum logic [1:0] {
        RD_EMPTY = 2'd0,
        RD_BUSY  = 2'd1,
        RD_FULL  = 2'd2
    } rd_state_t;

    // Level of ready_o whenever the stage has room for another word.
    localparam logic RD_IDLE_READY = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear that takes
// priority over increment. Used for the optional stage statistics.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count events, holding at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ready_delay.sv
// ready_delay: two-entry skid buffer that registers the backward (ready)
// path. ready_o is decoded from the state register only, so there is no
// combinational path from ready_i to ready_o. Full throughput, in order.
// Optional statistics counters are built when READY_DELAY_STATS_EN is defined.
module ready_delay
    import ready_delay_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i
`ifdef READY_DELAY_STATS_EN
    ,
    input  logic              clr_stats_i,
    output logic [CNT_W-1:0]  xfer_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

    rd_state_t         state_q;
    rd_state_t         state_d;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] skd_q;
    logic              in_fire;
    logic              out_fire;
    logic              load_out;
    logic              out_from_skd;
    logic              load_skd;

    assign ready_o  = (state_q == RD_FULL) ? ~RD_IDLE_READY : RD_IDLE_READY;
    assign valid_o  = (state_q != RD_EMPTY);
    assign data_o   = out_q;
    assign in_fire  = valid_i && ready_o;
    assign out_fire = valid_o && ready_i;

    // State register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= RD_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and register-load decode; OUT always keeps the older word.
    always_comb begin
        state_d      = state_q;
        load_out     = 1'b0;
        out_from_skd = 1'b0;
        load_skd     = 1'b0;
        case (state_q)
            RD_EMPTY: begin
                if (in_fire) begin
                    load_out = 1'b1;
                    state_d  = RD_BUSY;
                end
            end
            RD_BUSY: begin
                if (in_fire && out_fire) begin
                    load_out = 1'b1;
                end else if (in_fire) begin
                    load_skd = 1'b1;
                    state_d  = RD_FULL;
                end else if (out_fire) begin
                    state_d  = RD_EMPTY;
                end
            end
            RD_FULL: begin
                if (out_fire) begin
                    load_out     = 1'b1;
                    out_from_skd = 1'b1;
                    state_d      = RD_BUSY;
                end
            end
            default: begin
                state_d = RD_EMPTY;
            end
        endcase
    end

    // Output register: refilled from the input or promoted from the skid slot.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            out_q <= '0;
        end else if (load_out) begin
            out_q <= out_from_skd ? skd_q : data_i;
        end
    end

    // Skid register: catches the word accepted while the output is stalled.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            skd_q <= '0;
        end else if (load_skd) begin
            skd_q <= data_i;
        end
    end

`ifdef READY_DELAY_STATS_EN
    sat_counter #(.CNT_W(CNT_W)) u_xfer_cnt (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .clr_i    (clr_stats_i),
        .inc_i    (out_fire),
        .cnt_o    (xfer_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .clr_i    (clr_stats_i),
        .inc_i    (valid_o && !ready_i),
        .cnt_o    (stall_cnt_o)
    );
`endif

endmodule

// File: tb/tb_ready_delay.sv
// tb_ready_delay: scoreboard bench for the ready_delay skid buffer.
// The reference is a bounded FIFO of capacity two: ready is "fewer than two
// words held", valid is "at least one word held", data is the oldest word.
module tb_ready_delay;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk_i;
    logic              arst_n_i;
    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              ready_i;
`ifdef READY_DELAY_STATS_EN
    logic              clr_stats_i;
    logic [CNT_W-1:0]  xfer_cnt_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    int unsigned       m_xfer;
    int unsigned       m_stall;
`endif

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    logic [DATA_W-1:0] sb[$];

    ready_delay #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i)
`ifdef READY_DELAY_STATS_EN
        ,
        .clr_stats_i (clr_stats_i),
        .xfer_cnt_o  (xfer_cnt_o),
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reset empties the reference model.
    always @(negedge arst_n_i) begin
        sb.delete();
`ifdef READY_DELAY_STATS_EN
        m_xfer  = 0;
        m_stall = 0;
`endif
    end

    // Monitor: compare DUT against the FIFO model, then advance the model.
    always @(negedge clk_i) begin
        if (arst_n_i) begin
            logic exp_valid, exp_ready, in_f, out_f;
            exp_valid = (sb.size() > 0);
            exp_ready = (sb.size() < 2);
            check("valid_o", valid_o, exp_valid);
            check("ready_o", ready_o, exp_ready);
            if (exp_valid) check("data_o", data_o, sb[0]);
`ifdef READY_DELAY_STATS_EN
            check("xfer_cnt", xfer_cnt_o, m_xfer);
            check("stall_cnt", stall_cnt_o, m_stall);
            if (clr_stats_i) begin
                m_xfer  = 0;
                m_stall = 0;
            end else begin
                if (exp_valid && ready_i && m_xfer < 15) m_xfer++;
                if (exp_valid && !ready_i && m_stall < 15) m_stall++;
            end
`endif
            in_f  = valid_i && exp_ready;
            out_f = exp_valid && ready_i;
            if (out_f) begin
                void'(sb.pop_front());
                n_out++;
            end
            if (in_f) sb.push_back(data_i);
        end
    end

    // Hold a word on data_i until the stage accepts it (bounded wait).
    task automatic send(input logic [DATA_W-1:0] d);
        bit done;
        done    = 0;
        data_i  = d;
        valid_i = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            if (ready_o) done = 1;
            @(posedge clk_i);
            #1;
        end
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int base;
        int sent;
        int cyc;
        logic [DATA_W-1:0] cur;
        logic r0;

        arst_n_i = 1'b0;
        data_i   = '0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
`ifdef READY_DELAY_STATS_EN
        clr_stats_i = 1'b0;
`endif
        cycles(2);
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_data", data_o, 0);
        arst_n_i = 1'b1;
        cycles(1);

        // Reset mid-transfer: fill to FULL, then asynchronous pulse.
        ready_i = 1'b0;
        send(32'hA1);
        send(32'hA2);
        valid_i = 1'b0;
        check("full_ready", ready_o, 0);
        #1 arst_n_i = 1'b0;
        #1;
        check("arst_valid", valid_o, 0);
        check("arst_ready", ready_o, 1);
        check("arst_data", data_o, 0);
        arst_n_i = 1'b1;
        cycles(1);
        ready_i = 1'b1;
        send(32'hB0);
        valid_i = 1'b0;
        check("post_rst_valid", valid_o, 1);
        check("post_rst_data", data_o, 32'hB0);
        cycles(2);

        // Streaming: eight back-to-back words, one output per cycle.
        base    = n_out;
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) send(i);
        valid_i = 1'b0;
        cycles(1);
        check("stream_count", n_out - base, 8);
        check("stream_empty", valid_o, 0);

        // Backpressure fill: third word must be held by the source.
        ready_i = 1'b0;
        send(32'h11);
        send(32'h22);
        data_i  = 32'h33;
        valid_i = 1'b1;
        cycles(3);
        check("bp_ready", ready_o, 0);
        check("bp_head", data_o, 32'h11);
        ready_i = 1'b1;
        send(32'h33);
        valid_i = 1'b0;
        cycles(3);
        check("bp_drained", valid_o, 0);

        // Drain to empty from BUSY.
        ready_i = 1'b1;
        send(32'h5A);
        valid_i = 1'b0;
        check("drain_busy", data_o, 32'h5A);
        cycles(1);
        check("drain_empty", valid_o, 0);
        check("drain_ready", ready_o, 1);

        // Random stalls: 1000 words with random valid and ready.
        sent = 0;
        cyc  = 0;
        cur  = $urandom;
        while (sent < 1000 && cyc < 20000) begin
            data_i  = cur;
            valid_i = $urandom_range(0, 1);
            ready_i = $urandom_range(0, 1);
            if (cyc % 37 == 5) begin
                #2;
                r0      = ready_o;
                ready_i = ~ready_i;
                #1;
                check("ready_comb", ready_o, r0);
                ready_i = ~ready_i;
            end
            if (valid_i && ready_o) begin
                sent++;
                @(posedge clk_i);
                #1;
                cur = $urandom;
            end else begin
                @(posedge clk_i);
                #1;
            end
            cyc++;
        end
        check("random_sent", sent, 1000);
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int k = 0; k < 10 && sb.size() != 0; k++) cycles(1);
        check("random_drained", sb.size(), 0);

`ifdef READY_DELAY_STATS_EN
        // Stats: saturate the stall counter, then clear with an out_fire.
        ready_i = 1'b0;
        send(32'h77);
        valid_i = 1'b0;
        cycles(20);
        check("stall_sat", stall_cnt_o, 15);
        ready_i     = 1'b1;
        clr_stats_i = 1'b1;
        cycles(1);
        clr_stats_i = 1'b0;
        check("clr_xfer", xfer_cnt_o, 0);
        check("clr_stall", stall_cnt_o, 0);
`endif

        cycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
